axis_stream_fifo: RTL and testbench



---
 rtl/axis_stream_fifo.sv | 120 ++++++++++++
 tb/tb_axis_stream_fifo.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_stream_fifo.sv
// DEPTH-entry first-word-fall-through AXI-stream FIFO for the systolic datapath.
// Optional packet mode withholds the master side until a whole frame is stored.
module axis_stream_fifo #(
    parameter int N           = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 8,
    parameter int PACKET_MODE = 0,
    parameter int AF_THRESH   = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N*DATA_WIDTH-1:0]      s_tdata,
    input  logic                         s_tvalid,
    input  logic                         s_tlast,
    output logic                         s_tready,
    output logic [N*DATA_WIDTH-1:0]      m_tdata,
    output logic                         m_tvalid,
    output logic                         m_tlast,
    input  logic                         m_tready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [$clog2(DEPTH+1)-1:0]   frames,
    output logic                         almost_full
);

    localparam int W  = N * DATA_WIDTH;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] AF_LVL   = LW'(AF_THRESH);
    localparam logic [LW-1:0] ONE_LVL  = LW'(1);
    localparam logic [PW-1:0] ONE_PTR  = PW'(1);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("axis_stream_fifo: DEPTH must be a power of two >= 2");
        end
        if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_thresh
            $error("axis_stream_fifo: AF_THRESH must lie in 1..DEPTH");
        end
    endgenerate

    logic [W:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [W:0]    head;
    logic          push;
    logic          pop;
    logic          push_last;
    logic          pop_last;
    logic          not_empty;

    assign s_tready  = (level != FULL_LVL) & ~reset;
    assign push      = s_tvalid & s_tready;
    assign pop       = m_tvalid & m_tready;
    assign push_last = push & s_tlast;
    assign pop_last  = pop & m_tlast;

    assign head    = mem[rd_ptr];
    assign m_tdata = head[W-1:0];
    assign m_tlast = head[W];

    assign not_empty   = (level != '0);
    assign almost_full = (level >= AF_LVL);

    // Full override keeps frames longer than DEPTH from deadlocking
    generate
        if (PACKET_MODE != 0) begin : g_pkt
            assign m_tvalid = not_empty &
                              ((frames != '0) | (level == FULL_LVL));
        end else begin : g_stream
            assign m_tvalid = not_empty;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s_tlast, s_tdata};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ONE_PTR;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE_PTR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   level <= level + ONE_LVL;
                2'b01:   level <= level - ONE_LVL;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frames <= '0;
        end else begin
            unique case ({push_last, pop_last})
                2'b10:   frames <= frames + ONE_LVL;
                2'b01:   frames <= frames - ONE_LVL;
                default: frames <= frames;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_stream_fifo.sv
// Bench for axis_stream_fifo: streaming and packet-mode instances checked
// every cycle against a queue model plus hand-computed directed checks.
module tb_axis_stream_fifo;

    localparam int DEPTH = 8;
    localparam int AFT   = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] s_tdata  [2];
    logic        s_tvalid [2];
    logic        s_tlast  [2];
    logic        s_tready [2];
    logic [31:0] m_tdata  [2];
    logic        m_tvalid [2];
    logic        m_tlast  [2];
    logic        m_tready [2];
    logic [3:0]  level    [2];
    logic [3:0]  frames   [2];
    logic        almost_full [2];

    int vectors = 0;
    int miscompares = 0;
    bit started = 1'b0;

    logic [32:0] mq [2][$];

    always #5 clk = ~clk;

    axis_stream_fifo #(
        .N(4), .DATA_WIDTH(8), .DEPTH(DEPTH),
        .PACKET_MODE(0), .AF_THRESH(AFT)
    ) u_stream (
        .clk(clk), .reset(reset),
        .s_tdata(s_tdata[0]), .s_tvalid(s_tvalid[0]),
        .s_tlast(s_tlast[0]), .s_tready(s_tready[0]),
        .m_tdata(m_tdata[0]), .m_tvalid(m_tvalid[0]),
        .m_tlast(m_tlast[0]), .m_tready(m_tready[0]),
        .level(level[0]), .frames(frames[0]),
        .almost_full(almost_full[0])
    );

    axis_stream_fifo #(
        .N(4), .DATA_WIDTH(8), .DEPTH(DEPTH),
        .PACKET_MODE(1), .AF_THRESH(AFT)
    ) u_packet (
        .clk(clk), .reset(reset),
        .s_tdata(s_tdata[1]), .s_tvalid(s_tvalid[1]),
        .s_tlast(s_tlast[1]), .s_tready(s_tready[1]),
        .m_tdata(m_tdata[1]), .m_tvalid(m_tvalid[1]),
        .m_tlast(m_tlast[1]), .m_tready(m_tready[1]),
        .level(level[1]), .frames(frames[1]),
        .almost_full(almost_full[1])
    );

    function automatic int lasts(int i);
        int n = 0;
        foreach (mq[i][k]) if (mq[i][k][32]) n++;
        return n;
    endfunction

    function automatic bit exp_valid(int i);
        int sz = mq[i].size();
        if (sz == 0) return 1'b0;
        if (i == 0) return 1'b1;
        return (lasts(i) > 0) || (sz == DEPTH);
    endfunction

    // Model: a queue per instance, updated with the pre-edge inputs
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit pu;
            bit po;
            if (reset) begin
                mq[i].delete();
            end else begin
                pu = s_tvalid[i] && (mq[i].size() < DEPTH);
                po = exp_valid(i) && m_tready[i];
                if (po) void'(mq[i].pop_front());
                if (pu) mq[i].push_back({s_tlast[i], s_tdata[i]});
            end
        end
        started <= 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                bit ev;
                bit er;
                bit bad;
                int sz;
                sz = mq[i].size();
                ev = exp_valid(i);
                er = !reset && (sz != DEPTH);
                bad = (int'(level[i]) != sz) ||
                      (int'(frames[i]) != lasts(i)) ||
                      (m_tvalid[i] != ev) ||
                      (s_tready[i] != er) ||
                      (almost_full[i] != (sz >= AFT));
                if (ev && !bad)
                    bad = ({m_tlast[i], m_tdata[i]} != mq[i][0]);
                vectors++;
                if (bad) begin
                    miscompares++;
                    $display("FAIL cycle inst%0d t=%0t act lvl=%0d frm=%0d v=%0b rdy=%0b af=%0b d=%h l=%0b exp lvl=%0d frm=%0d v=%0b rdy=%0b af=%0b d=%h",
                             i, $time, level[i], frames[i], m_tvalid[i],
                             s_tready[i], almost_full[i], m_tdata[i],
                             m_tlast[i], sz, lasts(i), ev, er, sz >= AFT,
                             ev ? mq[i][0] : 33'h0);
                end
            end
        end
    end

    task automatic check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int i, bit v, logic [31:0] d, bit l);
        s_tvalid[i] = v;
        s_tdata[i]  = d;
        s_tlast[i]  = l;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            drive(i, 1'b0, 32'h0, 1'b0);
            m_tready[i] = 1'b0;
        end
        tick();
        tick();
        check("rst_level", int'(level[0]), 0);
        check("rst_tvalid", int'(m_tvalid[0]), 0);
        check("rst_ready", int'(s_tready[0]), 0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", int'(s_tready[0]), 1);

        // single beat latency
        m_tready[0] = 1'b1;
        drive(0, 1'b1, 32'h04030201, 1'b0);
        tick();
        check("lat_valid", int'(m_tvalid[0]), 1);
        check("lat_data", int'(m_tdata[0]), 32'h04030201);
        drive(0, 1'b0, 32'h0, 1'b0);
        tick();
        check("lat_level0", int'(level[0]), 0);

        // fill to full with sink stalled
        m_tready[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            drive(0, 1'b1, 32'(k), 1'b0);
            tick();
            if (k == 4) check("af_at5", int'(almost_full[0]), 0);
            if (k == 5) check("af_at6", int'(almost_full[0]), 1);
        end
        drive(0, 1'b0, 32'h0, 1'b0);
        check("full_ready", int'(s_tready[0]), 0);
        check("full_level", int'(level[0]), 8);
        check("full_af", int'(almost_full[0]), 1);
        m_tready[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("drain_valid", int'(m_tvalid[0]), 1);
            check("drain_data", int'(m_tdata[0]), k);
            tick();
            if (k == 0) check("ready_after_pop", int'(s_tready[0]), 1);
        end
        check("drain_empty", int'(m_tvalid[0]), 0);

        // continuous flow through pointer wrap
        for (int k = 0; k < 20; k++) begin
            drive(0, 1'b1, 32'(100 + k), 1'b0);
            tick();
            check("flow_level", int'(level[0]), 1);
            check("flow_data", int'(m_tdata[0]), 100 + k);
        end
        drive(0, 1'b0, 32'h0, 1'b0);
        tick();
        check("flow_end", int'(level[0]), 0);

        // packet mode: 3-beat frame
        m_tready[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1, 1'b1, 32'(16'hA0 + k), k == 2);
            tick();
            check("pkt_valid", int'(m_tvalid[1]), k == 2 ? 1 : 0);
        end
        drive(1, 1'b0, 32'h0, 1'b0);
        check("pkt_frames", int'(frames[1]), 1);
        for (int k = 0; k < 3; k++) begin
            check("pkt_data", int'(m_tdata[1]), 16'hA0 + k);
            check("pkt_last", int'(m_tlast[1]), k == 2 ? 1 : 0);
            tick();
        end
        check("pkt_frames0", int'(frames[1]), 0);
        check("pkt_valid0", int'(m_tvalid[1]), 0);

        // packet mode: full override with no tlast
        m_tready[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            drive(1, 1'b1, 32'(16'hB0 + k), 1'b0);
            tick();
            check("ovr_valid", int'(m_tvalid[1]), k == 7 ? 1 : 0);
        end
        drive(1, 1'b0, 32'h0, 1'b0);
        m_tready[1] = 1'b1;
        check("ovr_head", int'(m_tdata[1]), 16'hB0);
        tick();
        check("ovr_gate", int'(m_tvalid[1]), 0);
        check("ovr_lvl7", int'(level[1]), 7);
        drive(1, 1'b1, 32'h000000B8, 1'b1);
        tick();
        drive(1, 1'b0, 32'h0, 1'b0);
        for (int k = 1; k < 9; k++) begin
            check("ovr_drain", int'(m_tdata[1]), 16'hB0 + k);
            tick();
        end
        check("ovr_empty", int'(level[1]), 0);

        // reset mid-stream with 5 stored
        m_tready[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(0, 1'b1, 32'(200 + k), k == 2);
            tick();
        end
        drive(0, 1'b0, 32'h0, 1'b0);
        check("mid_level5", int'(level[0]), 5);
        reset = 1'b1;
        #1;
        check("mid_rst_ready", int'(s_tready[0]), 0);
        tick();
        check("mid_level", int'(level[0]), 0);
        check("mid_frames", int'(frames[0]), 0);
        check("mid_valid", int'(m_tvalid[0]), 0);
        reset = 1'b0;
        #1;
        check("mid_ready", int'(s_tready[0]), 1);
        m_tready[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("no_stale", int'(m_tvalid[0]), 0);
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
